// File: rtl/codeword_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : codeword_loader
// Description : Assembles BEATS bus beats into one codeword entry and writes it
//               to the even or odd codeword RAM, one bank-select per entry,
//               until both banks hold DEPTH entries.
//               Optional protocol checking is compiled in when the macro
//               CW_LOAD_CHK_EN is defined (s_tlast checks, full-bank error).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module codeword_loader #(
  parameter int ANTS  = 32,
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int BUS_W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [BUS_W-1:0]         s_tdata,
  input  logic                     s_tvalid,
  input  logic                     s_tlast,
  input  logic                     s_tuser,
  output logic                     s_tready,
  output logic                     o_wr_en_even,
  output logic                     o_wr_en_odd,
  output logic [$clog2(DEPTH)-1:0] o_wr_addr,
  output logic [ANTS*WIDTH-1:0]    o_wr_data,
  output logic                     o_load_done,
  output logic                     o_err
);

  localparam int ENTRY_W = ANTS * WIDTH;
  localparam int BEATS   = ENTRY_W / BUS_W;
  localparam int BCW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
  localparam logic [CW-1:0]  FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [BCW-1:0]       beat_q, beat_d;
  logic                 bank_q, bank_d;
  logic [ENTRY_W-1:0]   buf_q, buf_d;
  logic [CW-1:0]        cnt_even_q, cnt_even_d;
  logic [CW-1:0]        cnt_odd_q, cnt_odd_d;
  logic                 pend_q, pend_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [ENTRY_W-1:0]   data_q, data_d;
  logic                 done_q, done_d;

  logic                 hs_w;
  logic                 last_w;
  logic                 bank_w;
  logic                 full_w;
  logic                 early_w;
  logic                 strobe_w;
  logic [ENTRY_W-1:0]   entry_w;

  assign hs_w   = s_tvalid && (state_q == COLLECT);
  assign last_w = (beat_q == LAST_BEAT);
  // Bank select is only meaningful on beat 0; later beats reuse the latched copy.
  assign bank_w = (beat_q == '0) ? s_tuser : bank_q;
  assign full_w = bank_w ? (cnt_odd_q == FULL) : (cnt_even_q == FULL);
  // A start or reset in the WRITE cycle suppresses the strobe of that entry.
  assign strobe_w = (state_q == WRITE) && pend_q && !i_start && !i_reset;

`ifdef CW_LOAD_CHK_EN
  logic err_q, err_d;
  assign early_w = s_tlast && !last_w;
  assign o_err   = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign early_w      = 1'b0;
  assign o_err        = 1'b0;
`endif

  // Merge the incoming beat into the partially assembled entry (antenna 0 in LSBs).
  always_comb begin
    entry_w = buf_q;
    entry_w[int'(beat_q) * BUS_W +: BUS_W] = s_tdata;
  end

  // Next-state and datapath: collect beats, issue one write per entry, track fill.
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    bank_d     = bank_q;
    buf_d      = buf_q;
    cnt_even_d = cnt_even_q;
    cnt_odd_d  = cnt_odd_q;
    pend_d     = pend_q;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = done_q;
`ifdef CW_LOAD_CHK_EN
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
      end
      COLLECT: begin
        if (hs_w) begin
          buf_d  = entry_w;
          bank_d = bank_w;
          if (early_w) begin
            // Short entry: drop what was collected and restart at beat 0.
            beat_d = '0;
`ifdef CW_LOAD_CHK_EN
            err_d  = 1'b1;
`endif
          end else if (last_w) begin
            beat_d  = '0;
            state_d = WRITE;
            pend_d  = !full_w;
            // Address/data only change for entries that will really be written.
            if (!full_w) begin
              addr_d = bank_w ? cnt_odd_q[AW-1:0] : cnt_even_q[AW-1:0];
              data_d = entry_w;
            end
`ifdef CW_LOAD_CHK_EN
            if (full_w || !s_tlast) begin
              err_d = 1'b1;
            end
`endif
          end else begin
            beat_d = beat_q + BCW'(1);
          end
        end
      end
      WRITE: begin
        pend_d = 1'b0;
        if (strobe_w) begin
          if (bank_q) begin
            cnt_odd_d = cnt_odd_q + CW'(1);
          end else begin
            cnt_even_d = cnt_even_q + CW'(1);
          end
        end
        if ((cnt_even_d < FULL) || (cnt_odd_d < FULL)) begin
          state_d = COLLECT;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Start (re)begins a full load from any state, discarding partial work.
    if (i_start) begin
      state_d    = COLLECT;
      beat_d     = '0;
      buf_d      = '0;
      cnt_even_d = '0;
      cnt_odd_d  = '0;
      pend_d     = 1'b0;
      done_d     = 1'b0;
`ifdef CW_LOAD_CHK_EN
      err_d      = 1'b0;
`endif
    end
  end

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      bank_q     <= 1'b0;
      buf_q      <= '0;
      cnt_even_q <= '0;
      cnt_odd_q  <= '0;
      pend_q     <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
`ifdef CW_LOAD_CHK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      bank_q     <= bank_d;
      buf_q      <= buf_d;
      cnt_even_q <= cnt_even_d;
      cnt_odd_q  <= cnt_odd_d;
      pend_q     <= pend_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
`ifdef CW_LOAD_CHK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign s_tready     = (state_q == COLLECT);
  assign o_wr_en_even = strobe_w && !bank_q;
  assign o_wr_en_odd  = strobe_w && bank_q;
  assign o_wr_addr    = addr_q;
  assign o_wr_data    = data_q;
  assign o_load_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_codeword_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_codeword_loader
// Description : Randomized self-checking bench for codeword_loader. A per-entry
//               model predicts bank, address, data and error flag; a compare
//               process checks every write strobe. Honours CW_LOAD_CHK_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_codeword_loader;
  localparam int ANTS    = 32;
  localparam int WIDTH   = 32;
  localparam int DEPTH   = 64;
  localparam int BUS_W   = 64;
  localparam int ENTRY_W = ANTS * WIDTH;
  localparam int BEATS   = ENTRY_W / BUS_W;
  localparam int AW      = $clog2(DEPTH);
`ifdef CW_LOAD_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic                 i_clk = 1'b0;
  logic                 i_reset, i_start;
  logic [BUS_W-1:0]     s_tdata;
  logic                 s_tvalid, s_tlast, s_tuser;
  logic                 s_tready, o_wr_en_even, o_wr_en_odd, o_load_done, o_err;
  logic [AW-1:0]        o_wr_addr;
  logic [ENTRY_W-1:0]   o_wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { bit bank; int addr; logic [ENTRY_W-1:0] data; } wr_t;
  wr_t                exp_q[$];
  int                 cnt_m[2];
  bit                 err_m, done_m;
  logic [ENTRY_W-1:0] mem_exp [2][DEPTH];
  logic [ENTRY_W-1:0] obs_mem [2][DEPTH];

  codeword_loader #(.ANTS(ANTS), .WIDTH(WIDTH), .DEPTH(DEPTH), .BUS_W(BUS_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tready(s_tready), .o_wr_en_even(o_wr_en_even), .o_wr_en_odd(o_wr_en_odd),
    .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data), .o_load_done(o_load_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [ENTRY_W-1:0] act, input logic [ENTRY_W-1:0] exp);
    int bad;
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      bad = -1;
      for (int k = 0; k < BEATS; k++)
        if (bad < 0 && act[k*BUS_W +: BUS_W] !== exp[k*BUS_W +: BUS_W]) bad = k;
      $display("FAIL %s: beat %0d got %h, required %h", name, bad,
               act[bad*BUS_W +: BUS_W], exp[bad*BUS_W +: BUS_W]);
    end
  endtask

  function automatic void model_clear();
    cnt_m[0] = 0; cnt_m[1] = 0; err_m = 1'b0; done_m = 1'b0;
    exp_q.delete();
  endfunction

  // Every write strobe must match the oldest predicted write.
  always @(negedge i_clk) begin : p_cmp
    wr_t e;
    if (!i_reset && (o_wr_en_even || o_wr_en_odd)) begin
      chk("strobe_onehot", 64'(o_wr_en_even & o_wr_en_odd), 64'd0);
      chk("tready_in_write", 64'(s_tready), 64'd0);
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_strobe: odd=%0b addr=%0d, required no strobe", o_wr_en_odd, o_wr_addr);
      end else begin
        e = exp_q.pop_front();
        chk("wr_bank", 64'(o_wr_en_odd), 64'(e.bank));
        chk("wr_addr", 64'(o_wr_addr), 64'(e.addr));
        chk_data("wr_data", o_wr_data, e.data);
        obs_mem[o_wr_en_odd][o_wr_addr] <= o_wr_data;
      end
    end
  end

  task automatic send_beat(input logic [BUS_W-1:0] d, input bit user, input bit last, input int gap_pct);
    int guard;
    int gaps;
    bit hs;
    gaps = 0;
    while (gaps < 6 && int'($urandom_range(99)) < gap_pct) begin
      s_tvalid = 1'b0; gaps++;
      @(posedge i_clk); #1;
    end
    s_tdata = d; s_tuser = user; s_tlast = last; s_tvalid = 1'b1;
    guard = 0; hs = 1'b0;
    while (!hs && guard < 200) begin
      @(negedge i_clk); hs = s_tready; guard++;
      @(posedge i_clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    if (!hs) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: s_tready=%0b, required 1", s_tready);
    end
  endtask

  // tlast_pos: beat carrying s_tlast (-1 = never). With checking, an early
  // s_tlast ends the entry on that beat.
  task automatic send_entry(input bit bank, input int tlast_pos, input int tag, input bit pattern, input int gap_pct);
    logic [ENTRY_W-1:0] ent;
    logic [BUS_W-1:0]   beat;
    int nb;
    bit dropped, exp_stb;
    dropped = CHK && tlast_pos >= 0 && tlast_pos < BEATS-1;
    nb = dropped ? tlast_pos + 1 : BEATS;
    ent = '0;
    for (int k = 0; k < nb; k++) begin
      beat = pattern ? {32'(tag), 32'(k)} : {$urandom(), $urandom()};
      ent[k*BUS_W +: BUS_W] = beat;
      send_beat(beat, (k == 0) ? bank : bit'($urandom_range(1)), k == tlast_pos, gap_pct);
    end
    exp_stb = 1'b0;
    if (dropped) err_m = 1'b1;
    else begin
      if (CHK && tlast_pos != BEATS-1) err_m = 1'b1;
      if (cnt_m[bank] < DEPTH) begin
        exp_q.push_back('{bank, cnt_m[bank], ent});
        mem_exp[bank][cnt_m[bank]] = ent;
        cnt_m[bank]++;
        exp_stb = 1'b1;
      end else if (CHK) err_m = 1'b1;
      if (cnt_m[0] == DEPTH && cnt_m[1] == DEPTH) done_m = 1'b1;
    end
    @(negedge i_clk);
    chk("strobe_latency", 64'(o_wr_en_even | o_wr_en_odd), 64'(exp_stb));
    chk("err_flag", 64'(o_err), 64'(err_m));
    @(posedge i_clk); #1;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    model_clear();
  endtask

  task automatic check_load_end();
    int bad;
    @(negedge i_clk);
    chk("load_done", 64'(o_load_done), 64'(done_m));
    chk("tready_done", 64'(s_tready), 64'd0);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    for (int b = 0; b < 2; b++) begin
      bad = 0;
      for (int a = 0; a < DEPTH; a++)
        if (obs_mem[b][a] !== mem_exp[b][a]) bad++;
      chk(b ? "ram_odd" : "ram_even", 64'(bad), 64'd0);
    end
    @(posedge i_clk); #1;
  endtask

  initial begin
    int rem[2];
    int tag;
    bit b;
    logic [ENTRY_W-1:0] v;
    for (int bb = 0; bb < 2; bb++)
      for (int a = 0; a < DEPTH; a++) begin mem_exp[bb][a] = '0; obs_mem[bb][a] = '0; end
    model_clear();
    i_reset = 1'b1; i_start = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    @(negedge i_clk);
    chk("rst_tready", 64'(s_tready), 64'd0);
    chk("rst_wr_en", 64'({o_wr_en_even, o_wr_en_odd}), 64'd0);
    chk("rst_done", 64'(o_load_done), 64'd0);
    chk("rst_err", 64'(o_err), 64'd0);
    chk("rst_addr", 64'(o_wr_addr), 64'd0);
    chk_data("rst_data", o_wr_data, '0);
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("idle_tready", 64'(s_tready), 64'd0);
    @(posedge i_clk); #1;

    // Bank-sequential full load with {entry, beat} pattern data.
    pulse_start();
    for (int e = 0; e < 2*DEPTH; e++) send_entry(e >= DEPTH, BEATS-1, e, 1'b1, 0);
    check_load_end();
    chk("done_holds", 64'(o_load_done), 64'd1);
    chk("last_addr", 64'(o_wr_addr), 64'd63);
    v = o_wr_data;
    chk("last_beat0", v[63:0], {32'd127, 32'd0});
    chk("last_beat15", v[15*64 +: 64], {32'd127, 32'd15});
    v = obs_mem[0][5];
    chk("even5_beat3", v[3*64 +: 64], {32'd5, 32'd3});
    v = obs_mem[1][0];
    chk("odd0_beat0", v[63:0], {32'd64, 32'd0});

    // Interleaved random load with random valid gaps.
    pulse_start();
    @(negedge i_clk);
    chk("start_clears_done", 64'(o_load_done), 64'd0);
    @(posedge i_clk); #1;
    rem[0] = DEPTH; rem[1] = DEPTH;
    while (rem[0] + rem[1] > 0) begin
      b = (rem[0] == 0) ? 1'b1 : (rem[1] == 0) ? 1'b0 : bit'($urandom_range(1));
      rem[b]--;
      send_entry(b, BEATS-1, 0, 1'b0, 30);
    end
    check_load_end();

    // Early s_tlast on beat 5 of entry 3, then missing s_tlast.
    pulse_start();
    for (int e = 0; e < 3; e++) send_entry(1'b0, BEATS-1, e, 1'b1, 10);
    send_entry(1'b0, 5, 3, 1'b1, 10);
    send_entry(1'b0, BEATS-1, 4, 1'b1, 10);
    chk("addr_after_short", 64'(o_wr_addr), CHK ? 64'd3 : 64'd4);
    send_entry(1'b1, -1, 5, 1'b1, 10);

    // Overfilled even bank.
    pulse_start();
    tag = 100;
    while (cnt_m[0] < DEPTH) begin send_entry(1'b0, BEATS-1, tag, 1'b1, 0); tag++; end
    send_entry(1'b0, BEATS-1, tag, 1'b1, 0);
    @(negedge i_clk);
    chk("full_err", 64'(o_err), 64'(CHK));
    chk("full_not_done", 64'(o_load_done), 64'd0);
    chk("full_tready", 64'(s_tready), 64'd1);
    @(posedge i_clk); #1;

    // Abort by i_start at beat 9 of entry 10.
    pulse_start();
    send_entry(1'b0, 2, 200, 1'b1, 10);
    for (int e = 1; e < 10; e++) send_entry(bit'(e & 1), BEATS-1, 200 + e, 1'b1, 10);
    for (int k = 0; k < 9; k++) send_beat({32'd210, 32'(k)}, (k == 0) ? 1'b1 : 1'b0, 1'b0, 0);
    pulse_start();
    @(negedge i_clk);
    chk("abort_done", 64'(o_load_done), 64'd0);
    chk("abort_err", 64'(o_err), 64'd0);
    chk("abort_tready", 64'(s_tready), 64'd1);
    @(posedge i_clk); #1;
    send_entry(1'b0, BEATS-1, 220, 1'b1, 0);
    chk("abort_even_addr", 64'(o_wr_addr), 64'd0);
    send_entry(1'b1, BEATS-1, 221, 1'b1, 0);
    chk("abort_odd_addr", 64'(o_wr_addr), 64'd0);

    // Reset at beat 7.
    pulse_start();
    for (int k = 0; k < 7; k++) send_beat({32'd300, 32'(k)}, 1'b0, 1'b0, 0);
    s_tdata = {32'd300, 32'd7}; s_tvalid = 1'b1; i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    model_clear();
    @(negedge i_clk);
    chk("rst7_tready", 64'(s_tready), 64'd0);
    chk("rst7_wr_en", 64'({o_wr_en_even, o_wr_en_odd}), 64'd0);
    chk("rst7_addr", 64'(o_wr_addr), 64'd0);
    chk_data("rst7_data", o_wr_data, '0);
    chk("rst7_done_err", 64'({o_load_done, o_err}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      chk("rst7_idle_tready", 64'(s_tready), 64'd0);
    end
    @(posedge i_clk); #1;
    s_tvalid = 1'b0;
    pulse_start();
    send_entry(1'b1, BEATS-1, 301, 1'b1, 20);
    chk("rst7_restart_addr", 64'(o_wr_addr), 64'd0);
    chk("rst7_no_pending", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

endmodule
`default_nettype wire
